// File: rtl/serial_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_ctrl_pkg
// Brief    : State encoding shared by the bit-serial processor sequencer.
// Revision : 1.0
// ============================================================================
package serial_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2,
      S_HOLD  = 2'd3
   } ctrl_state_t;

endpackage : serial_ctrl_pkg
`default_nettype wire

// File: rtl/serial_op_control.sv
`default_nettype none
// ============================================================================
// Module   : serial_op_control
// Brief    : Sequencer producing load/shift strobes for a WIDTH-cycle serial op.
// Revision : 1.0
// ============================================================================
module serial_op_control
   import serial_ctrl_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter bit WAIT_RELEASE = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Execute,
   input  logic       LoadA,
   input  logic       LoadB,
   input  logic [2:0] F,
   input  logic [1:0] R,
   output logic       Ld_A,
   output logic       Ld_B,
   output logic       Shift_En,
   output logic [2:0] F_q,
   output logic [1:0] R_q,
   output logic       Busy,
   output logic       Done
);

   localparam int             CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

   ctrl_state_t   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          armed_q, armed_d;
   logic [2:0]    f_d;
   logic [1:0]    r_d;
   logic          w_start;

   assign w_start = Execute & armed_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         armed_q <= 1'b0;
         F_q     <= '0;
         R_q     <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         armed_q <= armed_d;
         F_q     <= f_d;
         R_q     <= r_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      armed_d  = armed_q;
      f_d      = F_q;
      r_d      = R_q;
      Shift_En = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Start outranks re-arming; armed only rises after Execute is seen low.
            if (w_start) begin
               state_d = S_SHIFT;
               count_d = '0;
               armed_d = 1'b0;
               f_d     = F;
               r_d     = R;
            end else if (!Execute) begin
               armed_d = 1'b1;
            end
         end
         S_SHIFT: begin
            Shift_En = 1'b1;
            Busy     = 1'b1;
            if (count_q == c_last) begin
               state_d = S_DONE;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_DONE: begin
            Busy    = 1'b1;
            Done    = 1'b1;
            armed_d = 1'b0;
            state_d = WAIT_RELEASE ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (!Execute) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   assign Ld_A = LoadA & (state_q == S_IDLE) & ~w_start & ~Reset;
   assign Ld_B = LoadB & (state_q == S_IDLE) & ~w_start & ~Reset;

endmodule : serial_op_control
`default_nettype wire

// File: tb/tb_serial_op_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_op_control
// Brief    : Directed self-checking bench for serial_op_control (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_serial_op_control;
   import serial_ctrl_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset, Execute, LoadA, LoadB;
   logic [2:0] F;
   logic [1:0] R;
   logic       Ld_A, Ld_B, Shift_En, Busy, Done;
   logic [2:0] F_q;
   logic [1:0] R_q;

   int checks = 0;
   int errors = 0;

   serial_op_control #(.WIDTH(8), .WAIT_RELEASE(1'b1)) dut (
      .Clk(Clk), .Reset(Reset), .Execute(Execute), .LoadA(LoadA), .LoadB(LoadB),
      .F(F), .R(R), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
      .F_q(F_q), .R_q(R_q), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Execute = 1'b1; LoadA = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({Ld_A, Ld_B, Shift_En, Busy, Done, F_q, R_q} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {Ld_A, Ld_B, Shift_En, Busy, Done, F_q, R_q}, 10'b0);
         end
      end
      LoadA = 1'b0; Reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if ({Shift_En, Busy, Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_exec_held cycle %0d: {Shift_En,Busy,Done}=%b expected 000",
                     i, {Shift_En, Busy, Done});
         end
      end
   endtask

   task automatic test_exec_hold();
      Execute = 1'b0;
      tick();
      Execute = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if ({Shift_En, Done, Busy} !== {(i <= 8), (i == 9), (i <= 9)}) begin
            errors++;
            $display("FAIL exec_hold cycle %0d: {Shift_En,Done,Busy}=%b expected %b",
                     i, {Shift_En, Done, Busy}, {(i <= 8), (i == 9), (i <= 9)});
         end
      end
      checks++;
      if (dut.state_q !== S_HOLD) begin
         errors++;
         $display("FAIL exec_hold_state: got %0d expected %0d", dut.state_q, S_HOLD);
      end
      Execute = 1'b0;
      tick();
      checks++;
      if (dut.state_q !== S_IDLE) begin
         errors++;
         $display("FAIL hold_release: state %0d expected %0d", dut.state_q, S_IDLE);
      end
   endtask

   task automatic test_pulse();
      ctrl_state_t exp;
      tick();
      Execute = 1'b1;
      tick();
      Execute = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) tick();
         exp = (k <= 7) ? S_SHIFT : (k == 8) ? S_DONE : (k == 9) ? S_HOLD : S_IDLE;
         checks++;
         if (dut.state_q !== exp || Shift_En !== (k <= 7)) begin
            errors++;
            $display("FAIL pulse k=%0d: state %0d Shift_En %b expected %0d %b",
                     k, dut.state_q, Shift_En, exp, (k <= 7));
         end
      end
   endtask

   task automatic test_loads();
      LoadA = 1'b1; Execute = 1'b0;
      #1;
      checks++;
      if (Ld_A !== 1'b1 || Ld_B !== 1'b0) begin
         errors++;
         $display("FAIL load_idle: Ld_A=%b Ld_B=%b expected 1 0", Ld_A, Ld_B);
      end
      tick();
      LoadA = 1'b0; LoadB = 1'b1; Execute = 1'b1;
      #1;
      checks++;
      if (Ld_B !== 1'b0) begin
         errors++;
         $display("FAIL load_vs_start: Ld_B=%b expected 0", Ld_B);
      end
      tick();
      LoadB = 1'b0; LoadA = 1'b1;
      #1;
      checks++;
      if (Shift_En !== 1'b1 || Ld_A !== 1'b0) begin
         errors++;
         $display("FAIL load_in_shift: Shift_En=%b Ld_A=%b expected 1 0", Shift_En, Ld_A);
      end
      LoadA = 1'b0; Execute = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      checks++;
      if (dut.state_q !== S_IDLE) begin
         errors++;
         $display("FAIL load_return_idle: state %0d expected %0d", dut.state_q, S_IDLE);
      end
   endtask

   task automatic test_latch();
      tick();
      F = 3'b001; R = 2'b10; Execute = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         tick();
         if (k == 2) begin
            F = 3'b110; R = 2'b01; Execute = 1'b0;
         end
         checks++;
         if (F_q !== 3'b001 || R_q !== 2'b10) begin
            errors++;
            $display("FAIL latch k=%0d: F_q=%b R_q=%b expected 001 10", k, F_q, R_q);
         end
      end
      Execute = 1'b1;
      tick();
      checks++;
      if (F_q !== 3'b110 || R_q !== 2'b01 || Shift_En !== 1'b1) begin
         errors++;
         $display("FAIL relatch: F_q=%b R_q=%b Shift_En=%b expected 110 01 1",
                  F_q, R_q, Shift_En);
      end
   endtask

   task automatic test_reset_mid_op();
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checks++;
      if (Shift_En !== 1'b0 || dut.count_q !== 3'd0 || F_q !== 3'b000 || dut.state_q !== S_IDLE) begin
         errors++;
         $display("FAIL reset_mid_op: Shift_En=%b count=%0d F_q=%b state=%0d expected 0 0 000 %0d",
                  Shift_En, dut.count_q, F_q, dut.state_q, S_IDLE);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (Shift_En !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_restart cycle %0d: Shift_En=%b expected 0", i, Shift_En);
         end
      end
      Execute = 1'b0;
      tick();
      Execute = 1'b1;
      tick();
      checks++;
      if (Shift_En !== 1'b1 || dut.count_q !== 3'd0) begin
         errors++;
         $display("FAIL restart_after_release: Shift_En=%b count=%0d expected 1 0",
                  Shift_En, dut.count_q);
      end
      Execute = 1'b0;
      for (int i = 0; i < 11; i++) tick();
   endtask

   initial begin
      Reset = 1'b1; Execute = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
      F = 3'b000; R = 2'b00;
      #2;
      test_reset();
      test_exec_hold();
      test_pulse();
      test_loads();
      test_latch();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_op_control
`default_nettype wire
